// File: rtl/debug_ctrl.sv
// Debug-mode controller: synchronizes step/resume buttons and sequences CPU pause/finish_debug.
// Optional button debouncing is enabled by defining DEBUG_DEBOUNCE_EN.
module debug_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned STEP_TIMEOUT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halted,
    input  logic        btn_step,
    input  logic        btn_resume,
    output logic        pause,
    output logic        finish_debug,
    output logic        in_debug,
    output logic [15:0] step_count
);

    typedef enum logic [2:0] {
        IDLE,
        HALTED,
        STEP,
        STEP_WAIT,
        RESUME,
        RESUME_WAIT
    } state_t;

    localparam int unsigned TW = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(STEP_TIMEOUT - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic [1:0]    btn_raw, sync1, sync2, level, level_q, btn_edge;

    // bit 0 = step, bit 1 = resume
    assign btn_raw = {btn_resume, btn_step};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef DEBUG_DEBOUNCE_EN
    localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);

    logic [DCW-1:0] deb_cnt [2];
    logic [1:0]     deb_level;

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_level <= '0;
            for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] != deb_level[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb_level[i] <= sync2[i];
                        deb_cnt[i]   <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign level = deb_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_q <= '0;
        else       level_q <= level;
    end

    assign btn_edge = level & ~level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            step_count <= '0;
        end else begin
            state <= state_next;
            if (state == STEP_WAIT && !halted) timer <= timer + 1'b1;
            else                               timer <= '0;
            if (state == IDLE && halted)
                step_count <= '0;
            else if (state_next == STEP && state == HALTED && step_count != '1)
                step_count <= step_count + 16'd1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:        if (halted) state_next = HALTED;
            HALTED: begin
                // Resume takes priority; a coincident step edge is dropped.
                if (btn_edge[1])      state_next = RESUME;
                else if (btn_edge[0]) state_next = STEP;
            end
            STEP:        state_next = STEP_WAIT;
            STEP_WAIT: begin
                if (halted)                     state_next = HALTED;
                else if (timer == TIMEOUT_LAST) state_next = IDLE;
            end
            RESUME:      state_next = RESUME_WAIT;
            RESUME_WAIT: if (!halted) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    assign pause        = (state != STEP);
    assign finish_debug = (state == RESUME);
    assign in_debug     = (state != IDLE);

endmodule

// File: tb/tb_debug_ctrl.sv
// Randomized bench for debug_ctrl against a cycle-indexed behavioural model.
// Build with DEBUG_DEBOUNCE_EN defined to exercise the debounced variant (DEBOUNCE_CYCLES=4).
module tb_debug_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 4;
    localparam int HIST = 8192;

    // model activity names
    localparam int M_IDLE = 0, M_HALT = 1, M_STEP = 2, M_SWAIT = 3, M_RES = 4, M_RWAIT = 5;

    logic        clk = 1'b0;
    logic        reset, halted, btn_step, btn_resume;
    logic        pause, finish_debug, in_debug;
    logic [15:0] step_count;

    int checks = 0;
    int errors = 0;

    bit bs  [2][HIST];
    bit acc [2][HIST];
    int run [2];
    int cyc, m_mode, m_timer, m_count;
    int hold_s, hold_r, hold_h;

    always #5 clk = ~clk;

    debug_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STEP_TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .halted      (halted),
        .btn_step    (btn_step),
        .btn_resume  (btn_resume),
        .pause       (pause),
        .finish_debug(finish_debug),
        .in_debug    (in_debug),
        .step_count  (step_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit bs_at(int b, int i);
        return (i < 0) ? 1'b0 : bs[b][i];
    endfunction

    function automatic bit acc_at(int b, int i);
        return (i < 0) ? 1'b0 : acc[b][i];
    endfunction

    task automatic model_reset();
        cyc = 0; run[0] = 0; run[1] = 0;
        m_mode = M_IDLE; m_timer = 0; m_count = 0;
    endtask

    // Clock edge number cyc: record the sampled buttons, derive accepted levels, then advance.
    task automatic model_step();
        bit es, er;
        int m;
        m = cyc;
        bs[0][m] = btn_step;
        bs[1][m] = btn_resume;
        for (int b = 0; b < 2; b++) begin
`ifdef DEBUG_DEBOUNCE_EN
            bit prev, syn;
            prev = acc_at(b, m - 1);
            syn  = bs_at(b, m - 2);
            acc[b][m] = prev;
            if (syn != prev) begin
                run[b]++;
                if (run[b] == DEB) begin
                    acc[b][m] = syn;
                    run[b] = 0;
                end
            end else begin
                run[b] = 0;
            end
`else
            acc[b][m] = bs_at(b, m - 1);
`endif
        end
        es = acc_at(0, m - 1) && !acc_at(0, m - 2);
        er = acc_at(1, m - 1) && !acc_at(1, m - 2);
        case (m_mode)
            M_IDLE:  if (halted) begin m_mode = M_HALT; m_count = 0; end
            M_HALT: begin
                if (er) m_mode = M_RES;
                else if (es) begin
                    m_mode  = M_STEP;
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                end
            end
            M_STEP:  begin m_mode = M_SWAIT; m_timer = 0; end
            M_SWAIT: begin
                if (halted) m_mode = M_HALT;
                else begin
                    m_timer++;
                    if (m_timer >= TO) m_mode = M_IDLE;
                end
            end
            M_RES:   m_mode = M_RWAIT;
            M_RWAIT: if (!halted) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
        endcase
        if (cyc < HIST - 1) cyc++;
    endtask

    task automatic compare_outputs();
        check("pause",        32'(pause),        32'(m_mode != M_STEP));
        check("finish_debug", 32'(finish_debug), 32'(m_mode == M_RES));
        check("in_debug",     32'(in_debug),     32'(m_mode != M_IDLE));
        check("step_count",   32'(step_count),   32'(m_count));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_outputs();
    endtask

    task automatic reach_halted(input string tag);
        int n;
        btn_step = 1'b0; btn_resume = 1'b0; halted = 1'b0;
        repeat (14) tick();
        halted = 1'b1;
        n = 0;
        while (m_mode != M_HALT && n < 20) begin tick(); n++; end
        check({tag, "_reach_halted"}, 32'(m_mode == M_HALT), 32'd1);
    endtask

    // Press a button until the model enters the given pulse state, then reset mid-pulse.
    task automatic reset_mid_pulse(input string tag, input bit use_resume, input int target);
        int n;
        reach_halted(tag);
        if (use_resume) btn_resume = 1'b1; else btn_step = 1'b1;
        n = 0;
        while (m_mode != target && n < 20) begin tick(); n++; end
        check({tag, "_pulse_seen"}, 32'(m_mode == target), 32'd1);
        #2 reset = 1'b1;
        #1;
        check({tag, "_rst_pause"},  32'(pause),        32'd1);
        check({tag, "_rst_finish"}, 32'(finish_debug), 32'd0);
        check({tag, "_rst_indbg"},  32'(in_debug),     32'd0);
        check({tag, "_rst_count"},  32'(step_count),   32'd0);
        btn_step = 1'b0; btn_resume = 1'b0; halted = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        repeat (12) tick();
    endtask

    initial begin
        reset = 1'b1; halted = 1'b0; btn_step = 1'b0; btn_resume = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_pause",  32'(pause),        32'd1);
        check("reset_finish", 32'(finish_debug), 32'd0);
        check("reset_indbg",  32'(in_debug),     32'd0);
        check("reset_count",  32'(step_count),   32'd0);
        reset = 1'b0;
        model_reset();

        // CPU running: step presses must be ignored.
        for (int i = 0; i < 24; i++) begin
            btn_step = i[2];
            tick();
        end
        check("run_indbg", 32'(in_debug),   32'd0);
        check("run_count", 32'(step_count), 32'd0);

        // Simultaneous step and resume edges from HALTED.
        reach_halted("both");
        btn_step = 1'b1; btn_resume = 1'b1;
        repeat (12) tick();
        check("both_count", 32'(step_count), 32'd0);
        halted = 1'b0;
        tick(); tick();
        check("both_idle", 32'(in_debug), 32'd0);

        // Randomized session traffic.
        hold_s = 0; hold_r = 0; hold_h = 0;
        btn_step = 1'b0; btn_resume = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if (hold_s == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 9);
            end
            if (hold_r == 0) begin
                btn_resume = ($urandom_range(0, 5) == 0);
                hold_r = btn_resume ? $urandom_range(1, 6) : $urandom_range(8, 40);
            end
            if (hold_h == 0) begin
                halted = ($urandom_range(0, 3) != 0);
                hold_h = halted ? $urandom_range(2, 15) : $urandom_range(1, 7);
            end
            hold_s--; hold_r--; hold_h--;
            tick();
        end

        reset_mid_pulse("rst_step", 1'b0, M_STEP);
        reset_mid_pulse("rst_resume", 1'b1, M_RES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
